// File: rtl/tpu_pkg.sv
// rtl/tpu_pkg.sv - shared types and helpers for the C-row drain
package tpu_pkg;

    localparam int unsigned LANES  = 4;
    localparam int unsigned LANE_W = 32;
    localparam int unsigned ROW_W  = LANES * LANE_W;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CAPT,
        ST_RD,
        ST_OUT
    } state_e;

    // Lane 0 is the most significant slice of the row.
    function automatic logic [LANE_W-1:0] lane_sel(input logic [ROW_W-1:0] row,
                                                   input logic [1:0]       lane);
        case (lane)
            2'd0:    return row[ROW_W-1 -: LANE_W];
            2'd1:    return row[ROW_W-1-LANE_W -: LANE_W];
            2'd2:    return row[ROW_W-1-2*LANE_W -: LANE_W];
            default: return row[LANE_W-1:0];
        endcase
    endfunction

endpackage

// File: rtl/tpu_c_rowbuf.sv
// rtl/tpu_c_rowbuf.sv - C row buffer, one write port, one registered read port
module tpu_c_rowbuf #(
    parameter int unsigned DEPTH = 64,
    parameter int unsigned WIDTH = 128,
    localparam int unsigned AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             wr_en_i,
    input  logic [AW-1:0]    wr_addr_i,
    input  logic [WIDTH-1:0] wr_data_i,
    input  logic             rd_en_i,
    input  logic [AW-1:0]    rd_addr_i,
    output logic [WIDTH-1:0] rd_data_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] rd_data_q;

    // Contents are intentionally not reset; stale rows survive across jobs.
    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
        if (rd_en_i) begin
            rd_data_q <= mem_q[rd_addr_i];
        end
    end

    assign rd_data_o = rd_data_q;

endmodule

// File: rtl/tpu_c_drain.sv
// rtl/tpu_c_drain.sv - captures TPU C-row writes and streams them out as 32-bit beats
module tpu_c_drain
    import tpu_pkg::*;
#(
    parameter int unsigned ADDR_BITS  = 16,
    parameter int unsigned DATAC_BITS = ROW_W,
    parameter int unsigned LANE_BITS  = LANE_W,
    parameter int unsigned DEPTH      = 64,
    localparam int unsigned ROW_BITS  = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    input  logic                  tpu_ap_done,
    input  logic                  c_wr_en,
    input  logic [ADDR_BITS-1:0]  c_index,
    input  logic [DATAC_BITS-1:0] c_data_in,
    output logic                  m_tvalid,
    input  logic                  m_tready,
    output logic [LANE_BITS-1:0]  m_tdata,
    output logic                  m_tlast,
    output logic                  busy,
    output logic                  err_oob,
    output logic [ROW_BITS:0]     row_count
);

    localparam logic [ADDR_BITS-1:0] DEPTH_IDX = ADDR_BITS'(DEPTH);
    localparam logic [ROW_BITS:0]    ROW_ONE   = (ROW_BITS+1)'(1);

    state_e                state_q, state_d;
    logic [ROW_BITS:0]     row_count_q, row_count_d;
    logic [ROW_BITS-1:0]   row_ptr_q, row_ptr_d;
    logic [1:0]            lane_q, lane_d;
    logic                  err_oob_q, err_oob_d;
    logic                  done_q, done_d;
    logic                  wr_en, rd_en;
    logic [DATAC_BITS-1:0] rd_data;
    logic                  idx_ok;
    logic [ROW_BITS:0]     idx_next, ptr_next;

    // Range check on the full index before it is truncated to a row address.
    assign idx_ok   = c_index < DEPTH_IDX;
    assign idx_next = {1'b0, c_index[ROW_BITS-1:0]} + ROW_ONE;
    assign ptr_next = {1'b0, row_ptr_q} + ROW_ONE;

    tpu_c_rowbuf #(
        .DEPTH (DEPTH),
        .WIDTH (DATAC_BITS)
    ) u_rowbuf (
        .clk       (clk),
        .wr_en_i   (wr_en),
        .wr_addr_i (c_index[ROW_BITS-1:0]),
        .wr_data_i (c_data_in),
        .rd_en_i   (rd_en),
        .rd_addr_i (row_ptr_q),
        .rd_data_o (rd_data)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            row_count_q <= '0;
            row_ptr_q   <= '0;
            lane_q      <= '0;
            err_oob_q   <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            row_count_q <= row_count_d;
            row_ptr_q   <= row_ptr_d;
            lane_q      <= lane_d;
            err_oob_q   <= err_oob_d;
            done_q      <= done_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        row_count_d = row_count_q;
        row_ptr_d   = row_ptr_q;
        lane_d      = lane_q;
        err_oob_d   = err_oob_q;
        done_d      = done_q;
        wr_en       = 1'b0;
        rd_en       = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    state_d     = ST_CAPT;
                    row_count_d = '0;
                    err_oob_d   = 1'b0;
                    done_d      = 1'b1;
                end
            end
            ST_CAPT: begin
                done_d = tpu_ap_done;
                if (c_wr_en) begin
                    if (idx_ok) begin
                        wr_en = 1'b1;
                        if (idx_next > row_count_q) begin
                            row_count_d = idx_next;
                        end
                    end else begin
                        err_oob_d = 1'b1;
                    end
                end
                // Completion uses the count including a same-cycle write.
                if (tpu_ap_done && !done_q) begin
                    if (row_count_d == '0) begin
                        state_d = ST_IDLE;
                    end else begin
                        row_ptr_d = '0;
                        state_d   = ST_RD;
                    end
                end
            end
            ST_RD: begin
                rd_en   = 1'b1;
                lane_d  = '0;
                state_d = ST_OUT;
            end
            ST_OUT: begin
                if (m_tready) begin
                    if (lane_q != 2'd3) begin
                        lane_d = lane_q + 2'd1;
                    end else if (ptr_next != row_count_q) begin
                        row_ptr_d = row_ptr_q + 1'b1;
                        state_d   = ST_RD;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign m_tvalid  = (state_q == ST_OUT);
    assign m_tdata   = m_tvalid ? lane_sel(rd_data, lane_q) : '0;
    assign m_tlast   = m_tvalid && (lane_q == 2'd3) && (ptr_next == row_count_q);
    assign busy      = (state_q != ST_IDLE);
    assign err_oob   = err_oob_q;
    assign row_count = row_count_q;

endmodule

// File: tb/tb_tpu_c_drain.sv
// tb/tb_tpu_c_drain.sv - randomized scoreboard bench for tpu_c_drain
module tb_tpu_c_drain;

    localparam int DEPTH = 64;

    logic         clk = 1'b0;
    logic         rst, in_valid, tpu_ap_done, c_wr_en;
    logic [15:0]  c_index;
    logic [127:0] c_data_in;
    logic         m_tvalid, m_tready, m_tlast, busy, err_oob;
    logic [31:0]  m_tdata;
    logic [6:0]   row_count;

    tpu_c_drain dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .tpu_ap_done (tpu_ap_done),
        .c_wr_en     (c_wr_en),
        .c_index     (c_index),
        .c_data_in   (c_data_in),
        .m_tvalid    (m_tvalid),
        .m_tready    (m_tready),
        .m_tdata     (m_tdata),
        .m_tlast     (m_tlast),
        .busy        (busy),
        .err_oob     (err_oob),
        .row_count   (row_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] data;
        logic        last;
    } beat_t;

    int           checks = 0;
    int           failures = 0;
    beat_t        exp_q[$];
    logic [127:0] model_mem [DEPTH];
    int           model_rc;
    bit           model_err;
    int           beat_cnt = 0;
    int           rdy_mode = 0;
    int           rdy_ph = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Ready pattern: 0 = always ready, 1 = 1,0,0 repeating, 2 = random.
    always @(posedge clk) begin
        #1;
        rdy_ph = (rdy_ph + 1) % 3;
        case (rdy_mode)
            0:       m_tready = 1'b1;
            1:       m_tready = (rdy_ph == 0);
            default: m_tready = 1'($urandom_range(0, 1));
        endcase
    end

    logic        held = 1'b0;
    logic [31:0] held_data;
    logic        held_last;
    beat_t       mon_e;

    always @(negedge clk) begin
        if (rst) begin
            held = 1'b0;
        end else begin
            if (held) begin
                check("stall_hold", {m_tvalid, m_tlast, m_tdata}, {1'b1, held_last, held_data});
            end
            held = 1'b0;
            if (m_tvalid && m_tready) begin
                beat_cnt++;
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_beat: got data %0h last %0b, expected no beat", m_tdata, m_tlast);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("beat", {m_tlast, m_tdata}, {mon_e.last, mon_e.data});
                end
            end else if (m_tvalid) begin
                held      = 1'b1;
                held_data = m_tdata;
                held_last = m_tlast;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic void model_write(input int idx, input logic [127:0] d);
        if (idx < DEPTH) begin
            model_mem[idx] = d;
            if (idx + 1 > model_rc) model_rc = idx + 1;
        end else begin
            model_err = 1'b1;
        end
    endfunction

    function automatic void push_expect();
        beat_t b;
        for (int r = 0; r < model_rc; r++) begin
            for (int l = 0; l < 4; l++) begin
                b.data = model_mem[r][127-32*l -: 32];
                b.last = (r == model_rc - 1) && (l == 3);
                exp_q.push_back(b);
            end
        end
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    function automatic logic [127:0] pat_row(input int i);
        logic [31:0] a, b, c, d;
        a = 32'(i) * 32'h11;
        b = 32'(i + 1) * 32'h11;
        c = 32'(i + 2) * 32'h11;
        d = 32'(i + 3) * 32'h11;
        return {a, b, c, d};
    endfunction

    task automatic start_job();
        in_valid = 1'b1;
        tick();
        in_valid  = 1'b0;
        model_rc  = 0;
        model_err = 1'b0;
    endtask

    task automatic wr(input int idx, input logic [127:0] d);
        c_wr_en   = 1'b1;
        c_index   = idx[15:0];
        c_data_in = d;
        model_write(idx, d);
        tick();
        c_wr_en = 1'b0;
    endtask

    task automatic complete(input bit with_wr, input int idx, input logic [127:0] d);
        tpu_ap_done = 1'b0;
        tick();
        tpu_ap_done = 1'b1;
        if (with_wr) begin
            c_wr_en   = 1'b1;
            c_index   = idx[15:0];
            c_data_in = d;
            model_write(idx, d);
        end
        push_expect();
        tick();
        c_wr_en = 1'b0;
        check("lat_rd_no_valid", m_tvalid, 1'b0);
        tick();
        check("lat_first_valid", m_tvalid, model_rc > 0);
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check("idle_timeout", n < 3000, 1'b1);
        check("queue_drained", exp_q.size(), 0);
        check("row_count", row_count, model_rc);
        check("err_oob", err_oob, model_err);
        tick();
    endtask

    task automatic pattern_job();
        start_job();
        for (int i = 0; i < 4; i++) wr(i, pat_row(i));
        complete(1'b0, 0, '0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; in_valid = 1'b0; tpu_ap_done = 1'b0; c_wr_en = 1'b0;
        c_index = '0; c_data_in = '0; m_tready = 1'b1;
        repeat (3) tick();
        check("rst_tvalid", m_tvalid, 1'b0);
        check("rst_tlast", m_tlast, 1'b0);
        check("rst_tdata", m_tdata, 32'h0);
        check("rst_busy", busy, 1'b0);
        check("rst_err", err_oob, 1'b0);
        check("rst_rowcnt", row_count, 7'd0);
        rst = 1'b0;
        tick();

        // Fill every row so later stale-row expectations are known.
        rdy_mode = 2;
        start_job();
        for (int i = 0; i < DEPTH; i++) wr(i, rand128());
        complete(1'b0, 0, '0);
        wait_idle();

        // Pattern job, always ready; an IDLE write first must be ignored.
        rdy_mode = 0;
        wr_idle_junk();
        pattern_job();
        wait_idle();
        check("busy_after", busy, 1'b0);

        rdy_mode = 1;
        pattern_job();
        wait_idle();

        // Repeated index and out-of-range write.
        rdy_mode = 2;
        start_job();
        wr(5, rand128());
        wr(5, rand128());
        wr(70, rand128());
        complete(1'b0, 0, '0);
        wait_idle();

        // ap_done high through start: only a fresh rising edge completes.
        rdy_mode = 0;
        start_job();
        repeat (5) tick();
        check("no_early_done", busy, 1'b1);
        complete(1'b0, 0, '0);
        wait_idle();

        // Reset while beat 7 is presented.
        start_job();
        for (int i = 0; i < 4; i++) wr(i, pat_row(i));
        beat_cnt = 0;
        complete(1'b0, 0, '0);
        begin
            int n = 0;
            while (beat_cnt < 6 && n < 200) begin
                @(negedge clk);
                n++;
            end
            check("beat6_timeout", n < 200, 1'b1);
        end
        tick();
        rst = 1'b1;
        tick();
        check("rst_mid_tvalid", m_tvalid, 1'b0);
        check("rst_mid_busy", busy, 1'b0);
        rst = 1'b0;
        exp_q.delete();
        tick();
        pattern_job();
        wait_idle();

        // Write in the completion cycle is part of the drain.
        start_job();
        wr(0, rand128());
        wr(1, rand128());
        complete(1'b1, 2, rand128());
        wait_idle();

        rdy_mode = 2;
        for (int j = 0; j < 6; j++) begin
            int nw;
            start_job();
            nw = $urandom_range(0, 8);
            for (int k = 0; k < nw; k++) wr($urandom_range(0, 70), rand128());
            complete(1'($urandom_range(0, 1)), $urandom_range(0, 66), rand128());
            wait_idle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    task automatic wr_idle_junk();
        c_wr_en   = 1'b1;
        c_index   = 16'd0;
        c_data_in = rand128();
        tick();
        c_wr_en = 1'b0;
    endtask

endmodule
